// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one fully pipelined ALU between two requesters.
//
// Purpose:
//   Arbitrates two valid/ready requesters onto a single ALU that accepts one
//   operation per cycle and returns its result a fixed LAT cycles later.
//   Contention is resolved round-robin through a 1-bit priority pointer.
//   A LAT-deep shift register remembers which requester owns each result,
//   so that the result is routed back to the correct response port.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req0_val/rdy/in0/in1/opsel requester 0 operation handshake and operands
//   req1_val/rdy/in0/in1/opsel requester 1 operation handshake and operands
//   resp0_val, resp1_val       per-requester result valid (no backpressure)
//   resp_data                  shared result data (0 when no result)
//   alu_in0/alu_in1/alu_opsel  operands to the ALU in the issue cycle (0 when idle)
//   alu_out                    ALU result, valid LAT cycles after issue
//   busy                       at least one operation in flight
module alu_arbiter #(
    parameter int W   = 32,
    parameter int LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_val,
    output logic         req0_rdy,
    input  logic [W-1:0] req0_in0,
    input  logic [W-1:0] req0_in1,
    input  logic         req0_opsel,
    input  logic         req1_val,
    output logic         req1_rdy,
    input  logic [W-1:0] req1_in0,
    input  logic [W-1:0] req1_in1,
    input  logic         req1_opsel,
    output logic         resp0_val,
    output logic         resp1_val,
    output logic [W-1:0] resp_data,
    output logic [W-1:0] alu_in0,
    output logic [W-1:0] alu_in1,
    output logic         alu_opsel,
    input  logic [W-1:0] alu_out,
    output logic         busy
);

    // prio = 0: requester 0 wins a tie; prio = 1: requester 1 wins a tie.
    logic           prio;
    logic           grant0;
    logic           grant1;
    logic           grant;

    // In-flight tracking: index 0 is the newest issue, index LAT-1 the oldest.
    logic [LAT-1:0] vld_p;
    logic [LAT-1:0] id_p;

    // Issue stage: arbitration and operand steering
    // Reset masks the grants so nothing can be accepted while reset is high.
    always_comb begin
        grant0 = !reset && req0_val && (!req1_val || !prio);
        grant1 = !reset && req1_val && (!req0_val ||  prio);
        grant  = grant0 || grant1;
    end

    assign req0_rdy = grant0;
    assign req1_rdy = grant1;

    always_comb begin
        alu_in0   = '0;
        alu_in1   = '0;
        alu_opsel = 1'b0;
        if (grant0) begin
            alu_in0   = req0_in0;
            alu_in1   = req0_in1;
            alu_opsel = req0_opsel;
        end else if (grant1) begin
            alu_in0   = req1_in0;
            alu_in1   = req1_in1;
            alu_opsel = req1_opsel;
        end
    end

    // After a grant the pointer moves to the other requester; idle cycles keep it.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (grant) begin
            prio <= !grant1;
        end
    end

    // Tracking stages p0 .. p(LAT-1): shift {valid, owner} alongside the ALU pipe
    // Clearing the valids on reset discards in-flight results even though the
    // ALU itself keeps producing them.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p <= '0;
            id_p  <= '0;
        end else begin
            vld_p[0] <= grant;
            id_p[0]  <= grant1;
            for (int i = 1; i < LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
                id_p[i]  <= id_p[i-1];
            end
        end
    end

    // Response stage: the oldest entry lines up with alu_out
    always_comb begin
        resp0_val = vld_p[LAT-1] && !id_p[LAT-1];
        resp1_val = vld_p[LAT-1] &&  id_p[LAT-1];
        resp_data = vld_p[LAT-1] ? alu_out : '0;
    end

    assign busy = |vld_p;

endmodule
